regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_dest  in  5  ALU destination register
- alu_result  in  32  ALU result
- load_issue  in  1  load sent to memory this cycle
- load_dest  in  5  load destination register
- load_type  in  3  LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6
- load_offset  in  2  address[1:0] of the load
- mem_readdatavalid  in  1  memory read data present
- mem_readdata  in  32  memory word, little-endian byte lanes
- merge_index  out  5  register-file read index for the LWL/LWR old value
- merge_data  in  32  register-file combinational read of merge_index
- rf_write_enable  out  1  register-file write strobe
- rf_write_index  out  5  register-file write index
- rf_write_data  out  32  register-file write data
- stall  out  1  upstream SHALL NOT assert load_issue; SHALL NOT assert alu_valid while the ALU buffer is full
- load_pending  out  1  high in WAIT_LOAD

Function
REQ-003 FSM states: IDLE and WAIT_LOAD.
- IDLE->WAIT_LOAD on load_issue; the block latches dest, type and offset.
- WAIT_LOAD->IDLE on mem_readdatavalid.
REQ-004 load_issue SHALL be ignored in WAIT_LOAD.
REQ-005 mem_readdatavalid SHALL be ignored in IDLE.
REQ-006 rf_write_* outputs SHALL be registered; every write appears exactly one cycle after its triggering input.
REQ-007 alu_valid in IDLE, or in WAIT_LOAD without mem_readdatavalid, SHALL produce a write of alu_result to alu_dest on the next cycle.
REQ-008 A load completion SHALL produce a write of the aligned load value to the latched dest on the next cycle.
REQ-009 Load alignment: byte k = mem_readdata[8k+7:8k].
- LB: sign-extend byte offset.
- LBU: zero-extend byte offset.
- LH/LHU: sign-extend or zero-extend the halfword at offset[1]; offset[0] ignored.
- LW: whole word; offset ignored.
REQ-010 LWL with offset k SHALL produce (mem_readdata << 8(3-k)) | (old & (0x00FFFFFF >> 8k)).
REQ-011 LWR with offset k SHALL produce (mem_readdata >> 8k) | (old & ~(0xFFFFFFFF >> 8k)).
REQ-012 merge_index SHALL equal the latched load dest throughout WAIT_LOAD, and 0 in IDLE.
REQ-013 The old value SHALL be rf_write_data when rf_write_enable=1 and rf_write_index=merge_index (forwarding); otherwise it SHALL be merge_data.
REQ-014 If alu_valid and mem_readdatavalid coincide in WAIT_LOAD:
- the load write SHALL go first (cycle+1);
- the ALU result SHALL be held in a one-entry buffer and written at cycle+2.
REQ-015 stall SHALL be high while in WAIT_LOAD or while the ALU buffer is full.
REQ-016 alu_valid while the buffer is full SHALL be ignored.
REQ-017 Any write whose index is 0 SHALL be issued with rf_write_enable=0 and still consume its slot.
REQ-018 rf_write_enable SHALL be high for at most one cycle per accepted result; results SHALL never be dropped or duplicated.
REQ-019 The undefined load_type values 7 and above SHALL behave as LW.

Reset
REQ-020 When reset is high at a clock edge, the next state SHALL be:
- state IDLE, ALU buffer empty;
- rf_write_enable=0, rf_write_index=0, rf_write_data=0;
- stall=0, load_pending=0, merge_index=0.
REQ-021 Reset during WAIT_LOAD SHALL discard the pending load; a later mem_readdatavalid for it SHALL be ignored.
REQ-022 Reset SHALL override simultaneous alu_valid, load_issue and mem_readdatavalid.

Structure
REQ-023 Package mips_wb_pkg SHALL hold the load_type encoding (enum), the FSM state enum, and the constant REG_ZERO=5'd0.
REQ-024 Alignment and merge SHALL be a purely combinational sub-module load_align.
- Inputs: type, offset, word, old.
- Output: result.
REQ-025 Total RTL SHALL be roughly 150-250 lines.

Verification
REQ-026 ALU write: alu_valid, dest=5, result=0x12345678 -> next cycle we=1, idx=5, data=0x12345678; the following cycle we=0.
REQ-027 LB sign extension: load_issue LB, dest=3, offset=2; readdata=0x00800000 two cycles later -> next cycle idx=3, data=0xFFFFFF80; LBU with the same stimulus -> data=0x00000080.
REQ-028 LWL merge: old r4=0xAABBCCDD; LWL offset=1 with readdata=0x11223344 -> data=0x3344CCDD; LWR offset=1 with the same inputs -> data=0xAA112233.
REQ-029 Collision and forwarding:
- pending LW dest=7; alu_valid dest=7, result=1 coincides with readdatavalid, readdata=9;
- expected: writes 9 then 1 on consecutive cycles, stall high during the buffered cycle;
- LWL forwarding case: the forwarded in-flight value is used as old, not merge_data.
REQ-030 Zero register: ALU dest=0 -> no rf_write_enable pulse; a LW to dest 0 completes FSM to IDLE with no write.
REQ-031 Reset mid-load: load_issue, then reset, then readdatavalid -> no write, state IDLE, stall=0.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared encodings for the MIPS writeback block: load types, FSM states and
// the hard-wired zero register index.
package mips_wb_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6
  } load_type_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: byte/halfword extraction with sign or
// zero extension, and the unaligned LWL/LWR merge with the old register value.
module load_align
  import mips_wb_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [31:0] i_old,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  // NOTE: o_result gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_result = i_word;
    case (i_type)
      LT_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      LT_LBU: o_result = {24'h000000, w_byte};
      LT_LH:  o_result = {{16{w_half[15]}}, w_half};
      LT_LHU: o_result = {16'h0000, w_half};
      // LWL fills the upper bytes from memory, keeps the low bytes of old.
      LT_LWL: begin
        case (i_offset)
          2'd0:    o_result = {i_word[7:0],  i_old[23:0]};
          2'd1:    o_result = {i_word[15:0], i_old[15:0]};
          2'd2:    o_result = {i_word[23:0], i_old[7:0]};
          default: o_result = i_word;
        endcase
      end
      // LWR fills the lower bytes from memory, keeps the high bytes of old.
      LT_LWR: begin
        case (i_offset)
          2'd0:    o_result = i_word;
          2'd1:    o_result = {i_old[31:24], i_word[31:8]};
          2'd2:    o_result = {i_old[31:16], i_word[31:16]};
          default: o_result = {i_old[31:8],  i_word[31:24]};
        endcase
      end
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: one outstanding load, ALU results, and a
// one-entry ALU buffer for the cycle where both complete together.
module regfile_writeback
  import mips_wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_result,
  input  logic        load_issue,
  input  logic [4:0]  load_dest,
  input  logic [2:0]  load_type,
  input  logic [1:0]  load_offset,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_readdata,
  output logic [4:0]  merge_index,
  input  logic [31:0] merge_data,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_index,
  output logic [31:0] rf_write_data,
  output logic        stall,
  output logic        load_pending
);

  wb_state_e   r_state;
  logic [4:0]  r_ld_dest;
  logic [2:0]  r_ld_type;
  logic [1:0]  r_ld_offset;

  logic        r_buf_valid;
  logic [4:0]  r_buf_dest;
  logic [31:0] r_buf_data;

  logic        r_we;
  logic [4:0]  r_idx;
  logic [31:0] r_data;

  logic        w_in_wait;
  logic        w_load_done;
  logic [31:0] w_old;
  logic [31:0] w_load_value;
  logic        w_wr_valid;
  logic [4:0]  w_wr_dest;
  logic [31:0] w_wr_data;
  logic        w_buf_load;
  logic        w_buf_drain;

  assign w_in_wait   = (r_state == ST_WAIT_LOAD);
  assign w_load_done = w_in_wait && mem_readdatavalid;
  assign merge_index = w_in_wait ? r_ld_dest : REG_ZERO;

  // The register file has not absorbed the write on its outputs yet, so a
  // same-index write in flight is the true old value for LWL/LWR.
  assign w_old = (r_we && (r_idx == merge_index)) ? r_data : merge_data;

  load_align u_load_align (
    .i_type   (r_ld_type),
    .i_offset (r_ld_offset),
    .i_word   (mem_readdata),
    .i_old    (w_old),
    .o_result (w_load_value)
  );

  // Write slot arbitration: load completion, then buffered ALU, then live ALU.
  always_comb begin
    w_wr_valid  = 1'b0;
    w_wr_dest   = REG_ZERO;
    w_wr_data   = '0;
    w_buf_load  = 1'b0;
    w_buf_drain = 1'b0;
    if (w_load_done) begin
      w_wr_valid = 1'b1;
      w_wr_dest  = r_ld_dest;
      w_wr_data  = w_load_value;
      w_buf_load = alu_valid && !r_buf_valid;
    end else if (r_buf_valid) begin
      w_wr_valid  = 1'b1;
      w_wr_dest   = r_buf_dest;
      w_wr_data   = r_buf_data;
      w_buf_drain = 1'b1;
    end else if (alu_valid) begin
      w_wr_valid = 1'b1;
      w_wr_dest  = alu_dest;
      w_wr_data  = alu_result;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ld_dest   <= REG_ZERO;
      r_ld_type   <= LT_LW;
      r_ld_offset <= 2'd0;
      r_buf_valid <= 1'b0;
      r_buf_dest  <= REG_ZERO;
      r_buf_data  <= '0;
      r_we        <= 1'b0;
      r_idx       <= REG_ZERO;
      r_data      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_issue) begin
            r_state     <= ST_WAIT_LOAD;
            r_ld_dest   <= load_dest;
            r_ld_type   <= load_type;
            r_ld_offset <= load_offset;
          end
        end
        ST_WAIT_LOAD: begin
          if (mem_readdatavalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_buf_load) begin
        r_buf_valid <= 1'b1;
        r_buf_dest  <= alu_dest;
        r_buf_data  <= alu_result;
      end else if (w_buf_drain) begin
        r_buf_valid <= 1'b0;
      end

      // Writes to r0 still occupy their slot but never strobe the file.
      r_we <= w_wr_valid && (w_wr_dest != REG_ZERO);
      if (w_wr_valid) begin
        r_idx  <= w_wr_dest;
        r_data <= w_wr_data;
      end
    end
  end

  assign rf_write_enable = r_we;
  assign rf_write_index  = r_idx;
  assign rf_write_data   = r_data;
  assign stall           = w_in_wait || r_buf_valid;
  assign load_pending    = w_in_wait;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised bench for regfile_writeback against an architectural model:
// in-order result queue with due edges and a shadow register file.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_result;
  logic        load_issue;
  logic [4:0]  load_dest;
  logic [2:0]  load_type;
  logic [1:0]  load_offset;
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;
  logic [4:0]  merge_index;
  logic [31:0] merge_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;
  logic        stall;
  logic        load_pending;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk               (clk),
    .reset             (reset),
    .alu_valid         (alu_valid),
    .alu_dest          (alu_dest),
    .alu_result        (alu_result),
    .load_issue        (load_issue),
    .load_dest         (load_dest),
    .load_type         (load_type),
    .load_offset       (load_offset),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .merge_index       (merge_index),
    .merge_data        (merge_data),
    .rf_write_enable   (rf_write_enable),
    .rf_write_index    (rf_write_index),
    .rf_write_data     (rf_write_data),
    .stall             (stall),
    .load_pending      (load_pending)
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 0) ? 32'h0 : 32'(32'h9E3779B9 * i);
  endfunction

  // Environment register file: absorbs the DUT's writes at the clock edge.
  logic [31:0] env_rf [32];
  logic        env_init;
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= init_val(i);
    end else if (rf_write_enable) begin
      env_rf[rf_write_index] <= rf_write_data;
    end
  end
  assign merge_data = env_rf[merge_index];

  // Reference model state.
  typedef struct {
    int          due;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t         q[$];
  logic [31:0] model_rf [32];
  bit          m_pend;
  bit          m_buf;
  logic [4:0]  m_dest;
  int          m_type;
  int          m_off;
  int          edge_no;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  function automatic logic [31:0] ref_align(int t, int off, logic [31:0] w, logic [31:0] old);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      0:       return (b >= 32'd128) ? b - 32'd256 : b;
      1:       return b;
      2:       return (h >= 32'd32768) ? h - 32'h10000 : h;
      3:       return h;
      5:       return (w << (8 * (3 - off))) | (old & (32'h00FFFFFF >> (8 * off)));
      6:       return (w >> (8 * off)) | (old & ~(32'hFFFFFFFF >> (8 * off)));
      default: return w;
    endcase
  endfunction

  task automatic step(input bit a_rst,
                      input bit a_li, input logic [4:0] a_ld, input logic [2:0] a_lt,
                      input logic [1:0] a_lo,
                      input bit a_av, input logic [4:0] a_ad, input logic [31:0] a_ar,
                      input bit a_rdv, input logic [31:0] a_rd);
    bit  was_pend;
    bit  was_buf;
    wr_t w;
    @(negedge clk);
    reset             = a_rst;
    load_issue        = a_li;
    load_dest         = a_ld;
    load_type         = a_lt;
    load_offset       = a_lo;
    alu_valid         = a_av;
    alu_dest          = a_ad;
    alu_result        = a_ar;
    mem_readdatavalid = a_rdv;
    mem_readdata      = a_rd;

    if (a_rst) begin
      q.delete();
      m_pend = 1'b0;
      m_buf  = 1'b0;
    end else begin
      was_pend = m_pend;
      was_buf  = m_buf;
      m_buf    = 1'b0;
      if (was_pend && a_rdv) begin
        q.push_back('{edge_no, m_dest, ref_align(m_type, m_off, a_rd, model_rf[m_dest])});
        m_pend = 1'b0;
        if (a_av && !was_buf) begin
          q.push_back('{edge_no + 1, a_ad, a_ar});
          m_buf = 1'b1;
        end
      end else if (a_av && !was_buf) begin
        q.push_back('{edge_no, a_ad, a_ar});
      end
      if (!was_pend && a_li) begin
        m_pend = 1'b1;
        m_dest = a_ld;
        m_type = int'(a_lt);
        m_off  = int'(a_lo);
      end
    end

    @(posedge clk);
    #1;
    if (a_rst) begin
      check("reset_we",   32'(rf_write_enable), 32'h0);
      check("reset_idx",  32'(rf_write_index),  32'h0);
      check("reset_data", rf_write_data,        32'h0);
    end else if (q.size() > 0 && q[0].due == edge_no) begin
      w = q.pop_front();
      check("wr_we",   32'(rf_write_enable), 32'(w.idx != 5'd0));
      check("wr_idx",  32'(rf_write_index),  32'(w.idx));
      check("wr_data", rf_write_data,        w.data);
      if (w.idx != 5'd0) model_rf[w.idx] = w.data;
    end else begin
      check("no_wr_we", 32'(rf_write_enable), 32'h0);
    end
    check("stall",        32'(stall),        32'(m_pend || m_buf));
    check("load_pending", 32'(load_pending), 32'(m_pend));
    check("merge_index",  32'(merge_index),  32'(m_pend ? m_dest : 5'd0));
    edge_no++;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 3'd0, 2'd0, 0, 5'd0, 32'h0, 0, 32'h0);
  endtask

  task automatic alu(input logic [4:0] d, input logic [31:0] r);
    step(0, 0, 5'd0, 3'd0, 2'd0, 1, d, r, 0, 32'h0);
  endtask

  task automatic issue(input logic [2:0] t, input logic [4:0] d, input logic [1:0] o);
    step(0, 1, d, t, o, 0, 5'd0, 32'h0, 0, 32'h0);
  endtask

  task automatic rdata(input logic [31:0] w);
    step(0, 0, 5'd0, 3'd0, 2'd0, 0, 5'd0, 32'h0, 1, w);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    edge_no  = 0;
    m_pend   = 1'b0;
    m_buf    = 1'b0;
    m_dest   = 5'd0;
    m_type   = 0;
    m_off    = 0;
    for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);
    env_init          = 1'b1;
    reset             = 1'b1;
    load_issue        = 1'b0;
    load_dest         = 5'd0;
    load_type         = 3'd0;
    load_offset       = 2'd0;
    alu_valid         = 1'b0;
    alu_dest          = 5'd0;
    alu_result        = 32'h0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = 32'h0;

    // Reset must win over every simultaneous request.
    step(1, 1, 5'd1, 3'd4, 2'd0, 1, 5'd2, 32'h1, 1, 32'h5);
    env_init = 1'b0;
    step(1, 0, 5'd0, 3'd0, 2'd0, 0, 5'd0, 32'h0, 0, 32'h0);

    // Plain ALU write, then a quiet cycle.
    alu(5'd5, 32'h12345678);
    check("alu_idx",  32'(rf_write_index), 32'd5);
    check("alu_data", rf_write_data,       32'h12345678);
    idle();
    check("alu_after_we", 32'(rf_write_enable), 32'h0);

    // LB / LBU at offset 2.
    issue(3'd0, 5'd3, 2'd2);
    idle();
    rdata(32'h00800000);
    check("lb_idx",  32'(rf_write_index), 32'd3);
    check("lb_data", rf_write_data,       32'hFFFFFF80);
    issue(3'd1, 5'd3, 2'd2);
    idle();
    rdata(32'h00800000);
    check("lbu_data", rf_write_data, 32'h00000080);

    // LH / LHU at offset 3: offset[0] is ignored.
    issue(3'd2, 5'd10, 2'd3);
    rdata(32'h80011234);
    check("lh_data", rf_write_data, 32'hFFFF8001);
    issue(3'd3, 5'd10, 2'd3);
    rdata(32'h80011234);
    check("lhu_data", rf_write_data, 32'h00008001);

    // LWL / LWR merges with r4 = AABBCCDD.
    alu(5'd4, 32'hAABBCCDD);
    issue(3'd5, 5'd4, 2'd1);
    rdata(32'h11223344);
    check("lwl_data", rf_write_data, 32'h3344CCDD);
    alu(5'd4, 32'hAABBCCDD);
    issue(3'd6, 5'd4, 2'd1);
    rdata(32'h11223344);
    check("lwr_data", rf_write_data, 32'hAA112233);

    // Collision: load writes first, ALU result is buffered one cycle.
    issue(3'd4, 5'd7, 2'd0);
    step(0, 0, 5'd0, 3'd0, 2'd0, 1, 5'd7, 32'h1, 1, 32'h9);
    check("coll_load_data", rf_write_data, 32'h9);
    check("coll_stall",     32'(stall),    32'h1);
    step(0, 0, 5'd0, 3'd0, 2'd0, 1, 5'd9, 32'hBAD, 0, 32'h0);
    check("coll_alu_idx",  32'(rf_write_index), 32'd7);
    check("coll_alu_data", rf_write_data,       32'h1);
    idle();

    // LWL whose old value is still in flight on the write port.
    alu(5'd8, 32'h55555555);
    idle();
    issue(3'd5, 5'd8, 2'd0);
    step(0, 0, 5'd0, 3'd0, 2'd0, 1, 5'd8, 32'hDEADBEEF, 0, 32'h0);
    rdata(32'h11223344);
    check("fwd_lwl_data", rf_write_data, 32'h44ADBEEF);

    // Zero register: slots consumed, no strobe.
    alu(5'd0, 32'hFFFFFFFF);
    check("r0_alu_we", 32'(rf_write_enable), 32'h0);
    issue(3'd4, 5'd0, 2'd0);
    rdata(32'h13579BDF);
    check("r0_load_we",      32'(rf_write_enable), 32'h0);
    check("r0_load_pending", 32'(load_pending),    32'h0);

    // Undefined load type behaves as LW.
    issue(3'd7, 5'd9, 2'd3);
    rdata(32'hCAFEF00D);
    check("type7_data", rf_write_data, 32'hCAFEF00D);

    // Reset while a load is outstanding discards it.
    issue(3'd4, 5'd6, 2'd0);
    step(1, 0, 5'd0, 3'd0, 2'd0, 0, 5'd0, 32'h0, 0, 32'h0);
    rdata(32'h0000FFFF);
    check("rst_mid_we",    32'(rf_write_enable), 32'h0);
    check("rst_mid_stall", 32'(stall),           32'h0);

    // Randomised traffic; load_issue is withheld only while the ALU buffer is full.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           !m_buf && ($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
